// File: rtl/data_memory_pkg.sv
// Shared constants and types for the data memory.
//   DMEM_DATA_WIDTH : width of one memory word
//   DMEM_DEPTH      : number of words (power of two)
//   DMEM_IDX_WIDTH  : number of address bits used to select a word
//   dmem_word_t     : one memory word
package data_memory_pkg;

    localparam int DMEM_DATA_WIDTH = 32;
    localparam int DMEM_DEPTH      = 64;
    localparam int DMEM_IDX_WIDTH  = $clog2(DMEM_DEPTH);

    typedef logic [DMEM_DATA_WIDTH-1:0] dmem_word_t;

endpackage

// File: rtl/data_memory.sv
// Word-addressed data memory for the single-cycle datapath.
// Stores are synchronous to clk; loads are combinational so a load
// completes in the same cycle it is issued.
//
// Ports
//   clk          : clock, writes happen on its rising edge
//   reset        : asynchronous active-low reset, clears every word
//   MemWrite     : store enable
//   MemRead      : load enable, gates MemData_out (0 when low)
//   read_address : word index shared by loads and stores; only the low
//                  log2(DEPTH) bits are used, so addresses wrap around
//   Write_data   : store data
//   MemData_out  : load data
module data_memory
    import data_memory_pkg::*;
#(
    parameter int DATA_WIDTH = DMEM_DATA_WIDTH,
    parameter int DEPTH      = DMEM_DEPTH,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  MemWrite,
    input  logic                  MemRead,
    input  logic [ADDR_WIDTH-1:0] read_address,
    input  logic [DATA_WIDTH-1:0] Write_data,
    output logic [DATA_WIDTH-1:0] MemData_out
);

    localparam int IDX_W = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];
    logic [IDX_W-1:0]      idx;

    // Word addressing: the upper address bits are deliberately dropped.
    assign idx = read_address[IDX_W-1:0];

    logic unused_addr_bits;
    assign unused_addr_bits = ^read_address[ADDR_WIDTH-1:IDX_W];

    // Reset clears the whole array at once; a store arriving while reset
    // is low is simply lost.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (MemWrite) begin
            mem[idx] <= Write_data;
        end
    end

    // Before a store edge this shows the old word, after it the new one.
    always_comb begin
        MemData_out = '0;
        if (MemRead) begin
            MemData_out = mem[idx];
        end
    end

endmodule

// File: tb/tb_data_memory.sv
module tb_data_memory;
    import data_memory_pkg::*;

    localparam int DEPTH = DMEM_DEPTH;

    logic        clk;
    logic        reset;
    logic        MemWrite;
    logic        MemRead;
    logic [31:0] read_address;
    dmem_word_t  Write_data;
    dmem_word_t  MemData_out;

    int checks = 0;
    int errors = 0;

    dmem_word_t model [DEPTH];

    typedef struct {
        logic        we;
        logic        re;
        logic [31:0] addr;
        dmem_word_t  wdata;
        dmem_word_t  exp;
        string       name;
    } vec_t;

    vec_t vecs [14];

    data_memory dut (
        .clk          (clk),
        .reset        (reset),
        .MemWrite     (MemWrite),
        .MemRead      (MemRead),
        .read_address (read_address),
        .Write_data   (Write_data),
        .MemData_out  (MemData_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input dmem_word_t got, input dmem_word_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic set_vec(input int i, input logic we, input logic re, input logic [31:0] addr,
                           input dmem_word_t wdata, input dmem_word_t exp, input string name);
        vecs[i].we    = we;
        vecs[i].re    = re;
        vecs[i].addr  = addr;
        vecs[i].wdata = wdata;
        vecs[i].exp   = exp;
        vecs[i].name  = name;
    endtask

    task automatic clear_model();
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
    endtask

    initial begin
        reset        = 1'b0;
        MemWrite     = 1'b0;
        MemRead      = 1'b1;
        read_address = 32'd0;
        Write_data   = '0;
        clear_model();

        // expected output is the value before the clock edge of that vector
        set_vec(0,  1, 0, 32'd0,  32'hDEADBEEF, 32'h0,        "write w0");
        set_vec(1,  0, 1, 32'd0,  32'h0,        32'hDEADBEEF, "read w0");
        set_vec(2,  1, 1, 32'd5,  32'hCAFEBABE, 32'h0,        "write w5 read old");
        set_vec(3,  0, 1, 32'd5,  32'h0,        32'hCAFEBABE, "read w5");
        set_vec(4,  0, 1, 32'd0,  32'h0,        32'hDEADBEEF, "read w0 no alias");
        set_vec(5,  0, 0, 32'd5,  32'h0,        32'h0,        "gated w5");
        set_vec(6,  0, 1, 32'd5,  32'h0,        32'hCAFEBABE, "ungated w5");
        set_vec(7,  1, 0, 32'd67, 32'h12345678, 32'h0,        "write addr 67");
        set_vec(8,  0, 1, 32'd3,  32'h0,        32'h12345678, "wrap read 3");
        set_vec(9,  0, 1, 32'd67, 32'h0,        32'h12345678, "wrap read 67");
        set_vec(10, 1, 1, 32'd3,  32'hA5A5A5A5, 32'h12345678, "rw same idx old");
        set_vec(11, 0, 1, 32'd3,  32'h0,        32'hA5A5A5A5, "rw same idx new");
        set_vec(12, 0, 0, 32'd3,  32'hFFFFFFFF, 32'h0,        "idle no change");
        set_vec(13, 0, 1, 32'd3,  32'h0,        32'hA5A5A5A5, "after idle");

        // reset held for a cycle; output zero during reset
        @(negedge clk);
        #1 check("out during reset", MemData_out, '0);
        @(negedge clk);
        reset = 1'b1;
        for (int a = 0; a < DEPTH; a++) begin
            read_address = a;
            #1 check($sformatf("reset word %0d", a), MemData_out, '0);
        end

        // table-driven directed vectors
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            MemWrite     = vecs[i].we;
            MemRead      = vecs[i].re;
            read_address = vecs[i].addr;
            Write_data   = vecs[i].wdata;
            #1 check(vecs[i].name, MemData_out, vecs[i].exp);
            if (vecs[i].we) model[vecs[i].addr % DEPTH] = vecs[i].wdata;
            @(posedge clk);
        end

        // read gating takes effect within a cycle, no edge needed
        @(negedge clk);
        MemWrite     = 1'b0;
        MemRead      = 1'b0;
        read_address = 32'd5;
        #1 check("gate low w5", MemData_out, '0);
        MemRead = 1'b1;
        #1 check("gate raised same cycle w5", MemData_out, 32'hCAFEBABE);

        // asynchronous reset between edges, with a store pending
        @(negedge clk);
        MemWrite     = 1'b1;
        MemRead      = 1'b1;
        read_address = 32'd5;
        Write_data   = 32'h0BADF00D;
        #1 reset = 1'b0;
        #1 check("async reset before edge", MemData_out, '0);
        read_address = 32'd9;
        Write_data   = 32'h99999999;
        @(posedge clk);
        #1 check("write blocked in reset", MemData_out, '0);
        clear_model();
        @(negedge clk);
        MemWrite = 1'b0;
        reset    = 1'b1;
        read_address = 32'd0;
        #1 check("after reset w0", MemData_out, '0);
        read_address = 32'd5;
        #1 check("after reset w5", MemData_out, '0);
        read_address = 32'd9;
        #1 check("after reset w9", MemData_out, '0);

        // randomized traffic against the array model
        for (int n = 0; n < 400; n++) begin
            logic        we, re;
            logic [31:0] addr;
            dmem_word_t  wd, exp;
            @(negedge clk);
            we   = ($urandom_range(0, 2) == 0);
            re   = ($urandom_range(0, 3) != 0);
            addr = $urandom_range(0, 15);
            if ($urandom_range(0, 3) == 0) addr = $urandom;
            wd   = $urandom;
            MemWrite     = we;
            MemRead      = re;
            read_address = addr;
            Write_data   = wd;
            exp = re ? model[addr % DEPTH] : '0;
            #1 check($sformatf("rand %0d addr %h", n, addr), MemData_out, exp);
            if (we) model[addr % DEPTH] = wd;
            @(posedge clk);
            #1;
            exp = re ? model[addr % DEPTH] : '0;
            check($sformatf("rand post %0d addr %h", n, addr), MemData_out, exp);
        end

        // full sweep of every word against the model
        @(negedge clk);
        MemWrite = 1'b0;
        MemRead  = 1'b1;
        for (int a = 0; a < DEPTH; a++) begin
            read_address = a + DEPTH * $urandom_range(0, 3);
            #1 check($sformatf("sweep word %0d", a), MemData_out, model[a]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
